// File: rtl/mpsub_seq_pkg.sv
// Shared definitions for the multi-precision subtract sequencer.
// Holds the state encoding and the limb width used by the datapath.
package mpsub_seq_pkg;

  localparam int LIMB = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : mpsub_seq_pkg

// File: rtl/mpsub_seq_sub.sv
// Shared 8-bit subtract cell: y = a - b - ci (mod 256), co = 1 on borrow.
// Purely combinational; the sequencer time-multiplexes a single instance.
module sub (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       ci,
  output logic [7:0] y,
  output logic       co
);

  logic [8:0] diff;

  // The ninth bit of the widened difference is the borrow out.
  assign diff = {1'b0, a} - {1'b0, b} - {8'b0, ci};
  assign y    = diff[7:0];
  assign co   = diff[8];

endmodule : sub

// File: rtl/mpsub_seq.sv
// Multi-precision subtract sequencer: Y = A - B - bin over WORDS byte limbs,
// one limb per clock, LSB first, borrow chained through a register.
module mpsub_seq
  import mpsub_seq_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [LIMB*WORDS-1:0] a_in,
  input  logic [LIMB*WORDS-1:0] b_in,
  input  logic                bin,
  output logic                busy,
  output logic                done,
  output logic [LIMB*WORDS-1:0] y_out,
  output logic                bout,
  output logic                zero
);

  localparam int W    = LIMB * WORDS;
  localparam int IDXW = $clog2(WORDS + 1);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

  state_e          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            borrow_q, borrow_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    y_q, y_d;
  logic            bout_q, bout_d;
  logic            zero_q, zero_d;

  logic [LIMB-1:0] sub_a, sub_b, sub_y;
  logic            sub_co;

  assign sub_a = a_q[idx_q*LIMB +: LIMB];
  assign sub_b = b_q[idx_q*LIMB +: LIMB];

  sub u_sub (
    .a  (sub_a),
    .b  (sub_b),
    .ci (borrow_q),
    .co (sub_co),
    .y  (sub_y)
  );

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    borrow_d = borrow_q;
    a_d      = a_q;
    b_d      = b_q;
    y_d      = y_q;
    bout_d   = bout_q;
    zero_d   = zero_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d      = a_in;
          b_d      = b_in;
          borrow_d = bin;
          idx_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        y_d[idx_q*LIMB +: LIMB] = sub_y;
        borrow_d                = sub_co;
        idx_d                   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          // Flags see the fully written result, including this final limb.
          bout_d  = sub_co;
          zero_d  = (y_d == '0);
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; the operand and
  // result registers are reset too, so an aborted operation leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      borrow_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      y_q      <= '0;
      bout_q   <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      borrow_q <= borrow_d;
      a_q      <= a_d;
      b_q      <= b_d;
      y_q      <= y_d;
      bout_q   <= bout_d;
      zero_q   <= zero_d;
    end
  end

  assign busy  = (state_q != IDLE);
  assign done  = (state_q == DONE);
  assign y_out = y_q;
  assign bout  = bout_q;
  assign zero  = zero_q;

endmodule : mpsub_seq

// File: tb/tb_mpsub_seq.sv
// Directed bench for mpsub_seq (WORDS=4): table-driven vectors plus
// hand-written sequences for busy length, ignored start and mid-run reset.
`timescale 1ns/1ps
module tb_mpsub_seq;

  localparam int WORDS = 4;
  localparam int W     = 8 * WORDS;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a_in, b_in;
  logic         bin;
  logic         busy, done, bout, zero;
  logic [W-1:0] y_out;

  int n_vec  = 0;
  int n_fail = 0;

  mpsub_seq #(.WORDS(WORDS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a_in  (a_in),
    .b_in  (b_in),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .y_out (y_out),
    .bout  (bout),
    .zero  (zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] y;
    logic         bout;
    logic         zero;
  } vec_t;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Present operands at a falling edge; returns #1 after the accepting edge E0.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
    @(negedge clk);
    a_in  = a;
    b_in  = b;
    bin   = bi;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts edges after E0 until done is seen; 0 edges elapsed on entry.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 50) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  vec_t vecs[5];
  int   cyc;
  int   busy_cnt;
  int   done_cnt;

  initial begin
    vecs[0] = '{32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b0, 1'b1};
    vecs[1] = '{32'h0000_0001, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[2] = '{32'h0000_0100, 32'h0000_0001, 1'b0, 32'h0000_00FF, 1'b0, 1'b0};
    vecs[3] = '{32'h8100_0000, 32'h0100_0000, 1'b0, 32'h8000_0000, 1'b0, 1'b0};
    vecs[4] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b0};

    rst_n = 1'b0;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    bin   = 1'b0;
    #12;
    check("reset_busy",  W'(busy),  W'(0));
    check("reset_done",  W'(done),  W'(0));
    check("reset_y",     y_out,     W'(0));
    check("reset_bout",  W'(bout),  W'(0));
    check("reset_zero",  W'(zero),  W'(0));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].bin);
      a_in = ~vecs[i].a;  // operands may change freely after acceptance
      b_in = ~vecs[i].b;
      wait_done(cyc);
      check($sformatf("v%0d_latency", i), W'(cyc), W'(WORDS));
      check($sformatf("v%0d_y", i),       y_out,   vecs[i].y);
      check($sformatf("v%0d_bout", i),    W'(bout), W'(vecs[i].bout));
      check($sformatf("v%0d_zero", i),    W'(zero), W'(vecs[i].zero));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_idle", i),    W'(busy), W'(0));
    end

    // Result holds in IDLE until the next accepted start.
    repeat (3) @(posedge clk);
    #1;
    check("hold_y", y_out, 32'h8000_0000);

    // Busy spans RUN (WORDS cycles) plus DONE (1 cycle).
    start_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    busy_cnt = busy ? 1 : 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      if (busy) busy_cnt++;
    end
    check("busy_len", W'(busy_cnt), W'(WORDS + 1));

    // A second start one cycle into RUN is dropped.
    start_op(32'd5, 32'd3, 1'b0);
    done_cnt = 0;
    @(negedge clk);
    a_in  = 32'd0;
    b_in  = 32'd1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (done) done_cnt++;
      @(posedge clk);
      #1;
    end
    check("ign_done_cnt", W'(done_cnt), W'(1));
    check("ign_y",        y_out,        32'd2);
    check("ign_bout",     W'(bout),     W'(0));

    // Asynchronous reset while idx == 2 aborts the operation.
    start_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", W'(busy), W'(0));
    check("arst_done", W'(done), W'(0));
    check("arst_y",    y_out,    W'(0));
    check("arst_bout", W'(bout), W'(0));
    check("arst_zero", W'(zero), W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    start_op(32'd10, 32'd4, 1'b0);
    wait_done(cyc);
    check("post_rst_latency", W'(cyc), W'(WORDS));
    check("post_rst_y",       y_out,   32'd6);
    check("post_rst_bout",    W'(bout), W'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule : tb_mpsub_seq
